// File: rtl/wb_intc.sv
// Wishbone B3 classic interrupt controller: per-source synchroniser, level/edge
// capture with programmable polarity, enable mask, W1C pending, software trigger.
module wb_intc #(
  parameter int NUM_IRQ     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wb_clk_i,
  input  logic               nrst_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic [2:0]         wb_cti_i,
  input  logic [1:0]         wb_bte_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_o
);

  localparam logic [31:0] IRQ_MASK = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << NUM_IRQ) - 32'd1);
  localparam int SW = SYNC_STAGES * 32;

  localparam logic [2:0] A_RAW      = 3'd0;
  localparam logic [2:0] A_PENDING  = 3'd1;
  localparam logic [2:0] A_ENABLE   = 3'd2;
  localparam logic [2:0] A_MODE     = 3'd3;
  localparam logic [2:0] A_POLARITY = 3'd4;
  localparam logic [2:0] A_VECTOR   = 3'd5;
  localparam logic [2:0] A_SOFT_SET = 3'd6;
  localparam logic [2:0] A_UNMAPPED = 3'd7;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  logic [SW-1:0] sync_q, sync_d;
  logic [31:0]   act_prev_q, act_prev_d;
  logic [31:0]   pending_q, pending_d;
  logic [31:0]   enable_q, enable_d;
  logic [31:0]   mode_q, mode_d;
  logic [31:0]   polarity_q, polarity_d;
  logic [31:0]   dat_q, dat_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          irq_q, irq_d;

  logic [31:0]   irq_ext_s, raw_s, act_s, lanes_s, wbits_s;
  logic [31:0]   w1c_s, soft_s, edge_next_s, masked_s, vector_s, rdata_s;
  logic          req_s, wr_s;
  logic [2:0]    reg_sel_s;
  logic [4:0]    first_s;
  logic          unused_s;

  // Cycle-type hints and byte offset carry no meaning for this slave.
  assign unused_s = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

  // Capture, register-file and bus-response next-state logic
  always_comb begin
    irq_ext_s              = 32'd0;
    irq_ext_s[NUM_IRQ-1:0] = irq_i;
    sync_d    = {sync_q[SW-33:0], irq_ext_s};
    raw_s     = sync_q[SW-1 -: 32];
    act_s     = ~(raw_s ^ polarity_q) & IRQ_MASK;

    req_s     = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    reg_sel_s = wb_adr_i[4:2];
    wr_s      = req_s & wb_we_i;
    lanes_s   = lane_mask(wb_sel_i);
    wbits_s   = wb_dat_i & lanes_s & IRQ_MASK;

    // W1C and software set act on edge-mode bits only; level bits track the input.
    w1c_s       = (wr_s && (reg_sel_s == A_PENDING))  ? (wbits_s & mode_q) : 32'd0;
    soft_s      = (wr_s && (reg_sel_s == A_SOFT_SET)) ? (wbits_s & mode_q) : 32'd0;
    edge_next_s = (act_s & ~act_prev_q) | soft_s | (pending_q & ~w1c_s);
    pending_d   = ((mode_q & edge_next_s) | (~mode_q & act_s)) & IRQ_MASK;
    act_prev_d  = act_s;

    enable_d   = (wr_s && (reg_sel_s == A_ENABLE))
               ? (((enable_q & ~lanes_s) | (wb_dat_i & lanes_s)) & IRQ_MASK) : enable_q;
    mode_d     = (wr_s && (reg_sel_s == A_MODE))
               ? (((mode_q & ~lanes_s) | (wb_dat_i & lanes_s)) & IRQ_MASK) : mode_q;
    polarity_d = (wr_s && (reg_sel_s == A_POLARITY))
               ? (((polarity_q & ~lanes_s) | (wb_dat_i & lanes_s)) & IRQ_MASK) : polarity_q;

    masked_s = pending_q & enable_q;
    first_s  = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      first_s = masked_s[i] ? i[4:0] : first_s;
    end
    vector_s = {(|masked_s), 26'd0, first_s};
    irq_d    = |masked_s;

    case (reg_sel_s)
      A_RAW:      rdata_s = raw_s;
      A_PENDING:  rdata_s = pending_q;
      A_ENABLE:   rdata_s = enable_q;
      A_MODE:     rdata_s = mode_q;
      A_POLARITY: rdata_s = polarity_q;
      A_VECTOR:   rdata_s = vector_s;
      A_SOFT_SET: rdata_s = 32'd0;
      default:    rdata_s = 32'd0;
    endcase

    ack_d = req_s & (reg_sel_s != A_UNMAPPED);
    err_d = req_s & (reg_sel_s == A_UNMAPPED);
    dat_d = (req_s && !wb_we_i && (reg_sel_s != A_UNMAPPED)) ? rdata_s : 32'd0;
  end

  // State and response registers
  always_ff @(posedge wb_clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync_q     <= {SW{1'b0}};
      act_prev_q <= 32'd0;
      pending_q  <= 32'd0;
      enable_q   <= 32'd0;
      mode_q     <= 32'd0;
      polarity_q <= IRQ_MASK;
      dat_q      <= 32'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      act_prev_q <= act_prev_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      polarity_q <= polarity_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
  assign irq_o    = irq_q;

endmodule

// File: doc/wb_intc.md
Name: wb_intc

Overview:
- Parametrised Wishbone B3 classic slave interrupt controller. It replaces the hard-wired 32-bit interrupt vector in the SoC top level.
- Inputs: up to NUM_IRQ asynchronous interrupt sources (UART at index 2, others spare).
- Per-source features: synchronisation, level or edge detect, programmable polarity, enable masking, W1C pending, software trigger.
- Output: one registered CPU interrupt plus a priority vector register.

Parameters:
- NUM_IRQ, 32, number of interrupt sources, legal range 1..32. Register bits at index NUM_IRQ and above read 0 and ignore writes.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser per source, legal range 2..3.

Ports:
- wb_clk_i  in  1  bus/system clock.
- nrst_i  in  1  asynchronous active-low reset.
- wb_adr_i  in  5  byte address; bits [4:2] select the register, bits [1:0] are ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte-lane write enables.
- wb_we_i  in  1  write strobe.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  slave strobe.
- wb_cti_i  in  3  ignored; classic cycles only.
- wb_bte_i  in  2  ignored.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  unmapped-address error.
- wb_rty_o  out  1  tied 0.
- irq_i  in  NUM_IRQ  raw interrupt sources, asynchronous.
- irq_o  out  1  CPU interrupt request, registered.

Behaviour:
- Register map:
  - 0x00 RAW (RO): synchronised inputs.
  - 0x04 PENDING (R/W1C).
  - 0x08 ENABLE (RW).
  - 0x0C MODE (RW): 1 = edge, 0 = level.
  - 0x10 POLARITY (RW): 1 = rising/high, 0 = falling/low.
  - 0x14 VECTOR (RO).
  - 0x18 SOFT_SET (WO, reads 0).
  - 0x1C is unmapped.
- Reset values (asynchronous, nrst_i low):
  - wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0, irq_o = 0.
  - All synchroniser and previous-level flops = 0.
  - PENDING = 0, ENABLE = 0, MODE = 0, POLARITY = all ones.
- Bus handshake:
  - Request = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o.
  - Response is registered one cycle after the request: exactly one of ack or err pulses for one cycle.
  - Back-to-back requests therefore complete every 2 cycles.
  - wb_dat_o is valid in the ack cycle and is 0 otherwise.
  - Writes commit on the request edge, per byte lane per wb_sel_i.
  - Address 0x1C gives err and no state change.
- Active level: act[i] = sync_out[i] XNOR POLARITY[i]. act_prev registers act each cycle.
- Level mode: PENDING[i] <= act[i] every cycle. W1C and SOFT_SET have no effect on level-mode bits.
- Edge mode:
  - set[i] = (act[i] & ~act_prev[i]) | SOFT_SET write bit.
  - clr[i] = W1C bit.
  - PENDING[i] <= set[i] | (PENDING[i] & ~clr[i]). Set wins over a simultaneous clear, so an event is never lost.
- Enable masking: ENABLE does not gate capture. It masks only irq_o and VECTOR.
- irq_o <= |(PENDING & ENABLE), registered.
- VECTOR bits:
  - bit31 = |(PENDING & ENABLE).
  - bits [4:0] = lowest index i with PENDING[i] & ENABLE[i], or 0 when none.
  - Other bits are 0.
- Latency (SYNC_STAGES = 2): an irq_i transition first sampled at edge 1 appears in RAW after edge 2, in PENDING after edge 3, and on irq_o after edge 4. Each extra sync stage adds one cycle.
- Configuration changes:
  - Writing POLARITY or MODE may produce one spurious edge event. Firmware clears PENDING afterwards.
  - PENDING reflects the new config from the cycle after the write.
- Reset mid-transfer: ack/err drop immediately, and no response is produced for the aborted request. A cyc/stb held through reset release gets its response one cycle after release.
- Pulse width: pulses narrower than one wb_clk_i period may be missed. Sources must be held for at least 2 cycles.

Test Plan:
1. Reset: nrst_i low mid-read of 0x14 -> ack drops asynchronously, irq_o = 0; after release POLARITY reads 0xFFFFFFFF and the other registers read 0.
2. Level mode, ENABLE = 0x4: hold irq_i[2] = 1 -> irq_o = 1 at edge 4, VECTOR reads 0x80000002; drop irq_i[2] -> irq_o = 0 four edges later; W1C 0x4 while high -> PENDING stays 0x4.
3. Edge mode, MODE = 0x3, ENABLE = 0x3: pulse irq_i[1] for 3 cycles, then irq_i[0] -> PENDING = 0x3, VECTOR = 0x80000000; W1C 0x1 -> VECTOR = 0x80000001; W1C 0x2 -> irq_o = 0.
4. Set/clear collision: a rising edge on irq_i[5] lands in the same cycle as a W1C 0x20 -> PENDING[5] = 1 afterwards.
5. Falling polarity plus software trigger: POLARITY = 0xFFFFFFFE, MODE = 0x1 -> a 1→0 transition on irq_i[0] sets PENDING[0]; a SOFT_SET write of 0x100 with MODE[8] = 1 sets PENDING[8] with no input activity.
6. Bus corner cases: access to 0x1C -> err pulse, no ack, no state change; ENABLE write with wb_sel_i = 0x1 and data 0xFFFFFFFF -> ENABLE = 0x000000FF; with NUM_IRQ = 8, ENABLE write of 0xFFFF -> reads 0xFF.
